// File: rtl/elevator_scheduler.sv
// Three-floor elevator controller: latches hall/cabin calls, serves them with a
// SCAN policy, and times door dwell and floor travel from a slow tick enable.
module elevator_scheduler #(
  parameter int DOOR_TICKS = 3,
  parameter int MOVE_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       A_e,
  input  logic       B_e,
  input  logic       C_e,
  input  logic       A_i,
  input  logic       B_i,
  input  logic       C_i,
  input  logic       alarm,
  output logic [1:0] EA,
  output logic       door,
  output logic       moving,
  output logic       dir,
  output logic [2:0] pending
);

  localparam int TMAX = (DOOR_TICKS > MOVE_TICKS) ? DOOR_TICKS : MOVE_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_TICKS);
  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_TICKS);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [1:0]    FLOOR_A   = 2'd0;
  localparam logic [1:0]    FLOOR_C   = 2'd2;

  typedef enum logic [1:0] {IDLE, OPEN, MOVE} state_t;

  state_t        state_q;
  logic [1:0]    ea_q;
  logic          door_q;
  logic          moving_q;
  logic          dir_q;
  logic [2:0]    pending_q;
  logic [TW-1:0] timer_q;

  logic [2:0] calls;
  logic [2:0] pending_d;
  logic       here_pend;
  logic       above;
  logic       below;
  logic       dir_d;
  logic [1:0] ea_step;

  always_comb begin
    calls     = {C_e | C_i, B_e | B_i, A_e | A_i};
    here_pend = pending_q[ea_q];
    above     = 1'b0;
    below     = 1'b0;
    for (int f = 0; f < 3; f++) begin
      if (pending_q[f] && (f > int'(ea_q))) above = 1'b1;
      if (pending_q[f] && (f < int'(ea_q))) below = 1'b1;
    end
    // SCAN: keep heading while work remains ahead, else turn around.
    if (ea_q == FLOOR_A)                 dir_d = 1'b1;
    else if (ea_q == FLOOR_C)            dir_d = 1'b0;
    else if (dir_q ? above : below)      dir_d = dir_q;
    else                                 dir_d = ~dir_q;
    if (dir_q) ea_step = (ea_q == FLOOR_C) ? ea_q : ea_q + 2'd1;
    else       ea_step = (ea_q == FLOOR_A) ? ea_q : ea_q - 2'd1;
    // Serving the current floor wins over a call for it in the same cycle.
    pending_d = pending_q | calls;
    if (state_q == OPEN) pending_d[ea_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ea_q      <= FLOOR_A;
      door_q    <= 1'b0;
      moving_q  <= 1'b0;
      dir_q     <= 1'b1;
      pending_q <= '0;
      timer_q   <= '0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (here_pend) begin
            state_q <= OPEN;
            door_q  <= 1'b1;
            timer_q <= DOOR_LOAD;
          end else if ((|pending_q) && !alarm) begin
            state_q  <= MOVE;
            moving_q <= 1'b1;
            dir_q    <= dir_d;
            timer_q  <= MOVE_LOAD;
          end
        end
        OPEN: begin
          // An overloaded cabin keeps the door open and restarts the dwell.
          if (alarm) begin
            timer_q <= DOOR_LOAD;
          end else if (tick) begin
            if (timer_q == TIMER_ONE) begin
              state_q <= IDLE;
              door_q  <= 1'b0;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q - TIMER_ONE;
            end
          end
        end
        MOVE: begin
          if (tick) begin
            if (timer_q == TIMER_ONE) begin
              state_q  <= IDLE;
              moving_q <= 1'b0;
              ea_q     <= ea_step;
              timer_q  <= '0;
            end else begin
              timer_q <= timer_q - TIMER_ONE;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          door_q   <= 1'b0;
          moving_q <= 1'b0;
        end
      endcase
    end
  end

  assign EA      = ea_q;
  assign door    = door_q;
  assign moving  = moving_q;
  assign dir     = dir_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scenario bench: each scenario pushes the floors it expects to be served, in
// order; a monitor pops them on every door opening and times door/travel.
module tb_elevator_scheduler;
  localparam int DOOR_TICKS = 3;
  localparam int MOVE_TICKS = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic A_e = 1'b0, B_e = 1'b0, C_e = 1'b0;
  logic A_i = 1'b0, B_i = 1'b0, C_i = 1'b0;
  logic alarm = 1'b0;
  logic [1:0] EA;
  logic door, moving, dir;
  logic [2:0] pending;

  int n_checks = 0;
  int n_fail = 0;
  int exp_q[$];

  elevator_scheduler #(.DOOR_TICKS(DOOR_TICKS), .MOVE_TICKS(MOVE_TICKS)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .A_e(A_e), .B_e(B_e), .C_e(C_e),
    .A_i(A_i), .B_i(B_i), .C_i(C_i),
    .alarm(alarm),
    .EA(EA), .door(door), .moving(moving), .dir(dir), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Tick every 4 clocks, free-running (also during reset).
  initial begin : tick_gen
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt = (cnt + 1) % 4;
      tick = (cnt == 0);
    end
  end

  initial begin : monitor
    logic door_p, mov_p;
    logic [1:0] ea_start;
    int open_t, move_t;
    door_p = 1'b0; mov_p = 1'b0; ea_start = 2'd0; open_t = 0; move_t = 0;
    forever begin
      @(posedge clk); #1;
      if (reset === 1'b1) begin
        open_t = 0;
        move_t = 0;
      end else begin
        if (door_p === 1'b1) begin
          if (alarm) open_t = 0;
          else if (tick) open_t++;
        end
        if ((mov_p === 1'b1) && tick) move_t++;
        if ((door === 1'b1) && (door_p !== 1'b1)) begin
          if (exp_q.size() == 0) check_eq("serve_unexpected", EA, 3);
          else check_eq("serve_floor", EA, exp_q.pop_front());
          $display("serve floor %0d pending=%b dir=%0d", EA, pending, dir);
          open_t = 0;
        end
        if ((door === 1'b0) && (door_p === 1'b1)) check_eq("door_ticks", open_t, DOOR_TICKS);
        if ((moving === 1'b1) && (mov_p !== 1'b1)) begin
          check_eq("move_alarm", alarm, 0);
          ea_start = EA;
          move_t = 0;
        end
        if ((moving === 1'b0) && (mov_p === 1'b1)) begin
          check_eq("move_ticks", move_t, MOVE_TICKS);
          check_eq("move_step", EA, dir ? int'(ea_start) + 1 : int'(ea_start) - 1);
        end
      end
      door_p = door;
      mov_p = moving;
    end
  end

  task automatic pulse_calls(input logic [5:0] c);
    @(negedge clk);
    {C_i, B_i, A_i, C_e, B_e, A_e} = c;
    @(negedge clk);
    {C_i, B_i, A_i, C_e, B_e, A_e} = 6'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (!door && !moving && (pending == 3'b000) && (exp_q.size() == 0)) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, ok, 1);
  endtask

  initial begin : stim
    bit ok;
    // Reset with calls held: nothing may latch.
    C_e = 1'b1; A_i = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0; C_e = 1'b0; A_i = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_pending", pending, 0);
    check_eq("rst_ea", EA, 0);
    check_eq("rst_door", door, 0);
    check_eq("rst_moving", moving, 0);
    check_eq("rst_dir", dir, 1);
    $display("reset done EA=%0d pending=%b", EA, pending);

    // Single call to C from A.
    exp_q.push_back(2);
    pulse_calls(6'b000100);
    check_eq("s1_latch", pending, 3'b100);
    @(posedge clk); #1;
    check_eq("s1_move", moving, 1);
    wait_quiet("s1_quiet");
    check_eq("s1_ea", EA, 2);

    // Cabin call at the current floor; clear beats a held call.
    do_reset();
    exp_q.push_back(0);
    @(negedge clk); A_i = 1'b1;
    @(posedge clk); #1;
    check_eq("s2_latch", pending, 3'b001);
    @(posedge clk); #1;
    check_eq("s2_open", door, 1);
    @(posedge clk); #1;
    check_eq("s2_clr_prio", pending, 3'b000);
    @(negedge clk); A_i = 1'b0;
    wait_quiet("s2_quiet");
    check_eq("s2_moving", moving, 0);

    // At B heading up with A and C pending: C first, then A.
    do_reset();
    exp_q.push_back(1);
    pulse_calls(6'b000010);
    wait_quiet("s3_to_b");
    check_eq("s3_ea_b", EA, 1);
    check_eq("s3_dir_up", dir, 1);
    exp_q.push_back(2); exp_q.push_back(0);
    pulse_calls(6'b000101);
    check_eq("s3_latch", pending, 3'b101);
    wait_quiet("s3_quiet");
    check_eq("s3_ea", EA, 0);

    // At B heading down with A_e and C_i: A first, then C.
    do_reset();
    exp_q.push_back(2);
    pulse_calls(6'b000100);
    wait_quiet("s4_to_c");
    exp_q.push_back(1);
    pulse_calls(6'b000010);
    wait_quiet("s4_to_b");
    check_eq("s4_ea_b", EA, 1);
    check_eq("s4_dir_down", dir, 0);
    exp_q.push_back(0); exp_q.push_back(2);
    pulse_calls(6'b100001);
    check_eq("s4_latch", pending, 3'b101);
    wait_quiet("s4_quiet");
    check_eq("s4_ea", EA, 2);

    // Overload while open at B, then overload blocks travel from B.
    exp_q.push_back(1);
    pulse_calls(6'b010000);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (door) begin ok = 1'b1; break; end
    end
    check_eq("s5_door_wait", ok, 1);
    @(negedge clk); alarm = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      check_eq("s5_hold", door, 1);
    end
    @(negedge clk); alarm = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (!door) begin ok = 1'b1; break; end
    end
    check_eq("s5_close_wait", ok, 1);
    @(negedge clk); alarm = 1'b1; A_e = 1'b1;
    @(negedge clk); A_e = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      check_eq("s5_no_move", moving, 0);
    end
    check_eq("s5_pending", pending, 3'b001);
    check_eq("s5_ea", EA, 1);
    exp_q.push_back(0);
    @(negedge clk); alarm = 1'b0;
    wait_quiet("s5_quiet");
    check_eq("s5_ea_a", EA, 0);

    // Reset in the middle of the B->C leg.
    pulse_calls(6'b000100);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (moving && (EA == 2'd1)) begin ok = 1'b1; break; end
    end
    check_eq("s6_mid_move", ok, 1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check_eq("s6_ea", EA, 0);
    check_eq("s6_moving", moving, 0);
    check_eq("s6_pending", pending, 0);
    check_eq("s6_door", door, 0);
    check_eq("s6_dir", dir, 1);
    @(negedge clk); reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_eq("s6_still", moving, 0);
    check_eq("s6_ea_still", EA, 0);
    check_eq("sb_final", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameter DOOR_TICKS, default 3, number of tick periods the door stays open per stop.
REQ-002 Parameter MOVE_TICKS, default 2, number of tick periods to travel one floor.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  one-clk-wide timebase enable pulse (1 Hz divider output); timers count only on cycles with tick=1.
REQ-006 A_e, B_e, C_e  input  1 each  external hall calls for floors A, B, C; level-sampled every clk.
REQ-007 A_i, B_i, C_i  input  1 each  internal cabin calls for floors A, B, C; level-sampled every clk.
REQ-008 alarm  input  1  overload flag from the people counter; 1 = cabin overloaded.
REQ-009 EA  output  2  current floor: 00=A, 01=B, 10=C; 11 never driven.
REQ-010 door  output  1  1 = door open.
REQ-011 moving  output  1  1 = state MOVE.
REQ-012 dir  output  1  last or current travel direction: 1 = up, 0 = down.
REQ-013 pending  output  3  latched calls, bit0=A, bit1=B, bit2=C.

Function
REQ-014 Call latch: pending[f] shall set in any cycle where the external or internal call for floor f is 1, and shall remain set until served.
REQ-015 Serve: pending[EA] shall be forced to 0 on every cycle the FSM is in OPEN; clear has priority over a same-cycle set for that floor.
REQ-016 FSM states IDLE, OPEN, MOVE; registered outputs; door=1 only in OPEN, moving=1 only in MOVE.
REQ-017 IDLE, pending[EA]=1: next state OPEN, door timer loaded with DOOR_TICKS.
REQ-018 IDLE, pending[EA]=0, other pending bit set, alarm=0: choose direction, next state MOVE, move timer loaded with MOVE_TICKS.
REQ-019 Direction choice (SCAN): keep dir if any call exists beyond EA in dir; otherwise reverse; at floor A dir forced to 1, at floor C dir forced to 0.
REQ-020 IDLE with alarm=1 shall never enter MOVE; a call at the current floor may still enter OPEN.
REQ-021 MOVE: timer decrements on each tick; on the tick where timer is 1, EA steps one floor in dir and next state is IDLE.
REQ-022 EA shall never step below A or above C; a step request that would leave that range is not generated.
REQ-023 OPEN: timer decrements on each tick; on the tick where timer is 1 and alarm=0, next state IDLE (door=0).
REQ-024 OPEN with alarm=1: timer reloaded to DOOR_TICKS every cycle; door held open until alarm=0 plus a full DOOR_TICKS.
REQ-025 Calls arriving during MOVE are latched only; route decision is re-evaluated in IDLE at each floor arrival.
REQ-026 Latency: IDLE decision to state change is one clk; a floor is served within one clk of arrival if pending.
REQ-027 Timer widths sized from DOOR_TICKS and MOVE_TICKS; values 1..15 shall be supported.

Reset
REQ-028 reset=1 at any clk edge, including mid-MOVE or mid-OPEN: state IDLE, EA=00, door=0, moving=0, dir=1, pending=000, timers=0.
REQ-029 Calls and tick asserted in the reset cycle shall be ignored.

Verification
REQ-030 Reset, then C_e pulse one clk, tick every 4 clk -> pending=100, MOVE, EA 00->01 after 2 ticks, IDLE, MOVE, EA=10 after 2 more ticks, OPEN, pending=000, door=1 for 3 ticks.
REQ-031 At EA=00 idle, A_i=1 -> OPEN next clk, pending[0] stays 0 while door=1, door=0 after 3 ticks.
REQ-032 At EA=01 dir=1, pending=101 -> moves up to C first, serves C, then dir=0, moves to A.
REQ-033 OPEN at B with alarm=1 for 10 ticks -> door=1 throughout; after alarm=0 door closes exactly 3 ticks later; no MOVE while alarm=1 in IDLE.
REQ-034 reset asserted mid-MOVE between B and C -> next clk EA=00, moving=0, pending=000; no further motion without new calls.
REQ-035 A_e and C_i asserted same clk at EA=01 dir=0 -> pending=101, travels down to A first, then up to C.
